// File: rtl/recip_normalizer_pkg.sv
// Shared constants for the reciprocal normalizer: default widths, the 3QP value 2.0
// and the width of the signed scale exponent.
package recip_normalizer_pkg;

  localparam int W_DEF = 32;
  localparam int F_DEF = 16;
  localparam int P_DEF = 22;
  localparam int SCL_W = 8;

  localparam logic [P_DEF+2:0] TWO_P = (P_DEF + 3)'(1) << (P_DEF + 1);

endpackage

// File: rtl/msb_find.sv
// Combinational priority encoder: index of the most significant set bit, plus an
// all-zero flag (index reads 0 when the vector is zero).
module msb_find #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         vec_i,
  output logic [$clog2(WIDTH)-1:0] idx_o,
  output logic                     zero_o
);

  // NOTE: every output gets a default first so no path through the loop infers a latch.
  always_comb begin
    idx_o  = '0;
    zero_o = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) begin
        idx_o  = ($clog2(WIDTH))'(i);
        zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/recip_normalizer.sv
// Two-stage valid/ready pipeline that normalizes |d| into [2.0, 4.0) as unsigned 3QP
// and emits the scale and sign so that 1/d = sign * (1/out_x) * 2^out_scl.
module recip_normalizer
  import recip_normalizer_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int F = F_DEF,
  parameter int P = P_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P+2:0]     out_x,
  output logic [SCL_W-1:0] out_scl,
  output logic             out_sign,
  output logic             out_zero,
  output logic             side_sign_d1,
  output logic [SCL_W-1:0] side_scl_d1,
  output logic             side_zero_d1,
  output logic             side_vld_d1
);

  localparam int XW = P + 3;
  localparam int MW = $clog2(W);
  localparam int SW = W + XW;
  localparam logic [XW-1:0] X_TWO = XW'(1) << (P + 1);

  // Holds in_ready low until the first clock edge after reset release.
  logic rdy_en_q;

  logic         s1_valid_q, s1_valid_d;
  logic         s1_sign_q, s1_zero_q;
  logic [W-1:0] s1_abs_q;

  logic             out_valid_q, out_valid_d;
  logic [XW-1:0]    out_x_q, out_x_d;
  logic [SCL_W-1:0] out_scl_q, out_scl_d;
  logic             out_sign_q, out_sign_d, out_zero_q, out_zero_d;

  logic [MW-1:0] msb_idx;
  logic          abs_zero;
  logic [SW-1:0] ext;
  int            e;

  logic in_fire, s2_advance;

  assign s2_advance = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready   = rdy_en_q && (!s1_valid_q || s2_advance);
  assign in_fire    = in_valid && in_ready;

  assign s1_valid_d  = in_fire ? 1'b1 : (s2_advance ? 1'b0 : s1_valid_q);
  assign out_valid_d = s2_advance ? 1'b1 : (out_valid_q && !out_ready);

  msb_find #(.WIDTH(W)) u_msb_find (
    .vec_i  (s1_abs_q),
    .idx_o  (msb_idx),
    .zero_o (abs_zero)
  );

  // e places the leading one of |d| at bit P+1; right shifts simply drop low bits.
  always_comb begin
    ext = SW'(s1_abs_q);
    e   = (P + 1) - int'(msb_idx);
    if (abs_zero) begin
      out_x_d = X_TWO;
    end else if (e >= 0) begin
      out_x_d = XW'(ext << e);
    end else begin
      out_x_d = XW'(ext >> (-e));
    end
    out_scl_d  = s1_zero_q ? '0 : SCL_W'(e + F - P);
    out_sign_d = s1_zero_q ? 1'b0 : s1_sign_q;
    out_zero_d = s1_zero_q;
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_abs_q   <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      s1_valid_q <= s1_valid_d;
      if (in_fire) begin
        s1_sign_q <= in_d[W-1];
        s1_abs_q  <= in_d[W-1] ? ('0 - in_d) : in_d;
        s1_zero_q <= (in_d == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_x_q     <= X_TWO;
      out_scl_q   <= '0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_advance) begin
        out_x_q    <= out_x_d;
        out_scl_q  <= out_scl_d;
        out_sign_q <= out_sign_d;
        out_zero_q <= out_zero_d;
      end
    end
  end

  // Sideband trails the output by one cycle to line up with the LUT read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      side_sign_d1 <= 1'b0;
      side_scl_d1  <= '0;
      side_zero_d1 <= 1'b0;
      side_vld_d1  <= 1'b0;
    end else begin
      side_sign_d1 <= out_sign_q;
      side_scl_d1  <= out_scl_q;
      side_zero_d1 <= out_zero_q;
      side_vld_d1  <= out_valid_q && out_ready;
    end
  end

  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_scl   = out_scl_q;
  assign out_sign  = out_sign_q;
  assign out_zero  = out_zero_q;

endmodule
